// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : atm_pkg
//  Purpose  : Shared encodings for the ATM session controller: FSM states,
//             operation codes, error codes and account initialisation values.
//  Revision : 1.0  initial release
// ============================================================================
package atm_pkg;

  // FSM state encodings (also driven on the state output)
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_LANG  = 4'd1;
  localparam logic [3:0] ST_PIN   = 4'd2;
  localparam logic [3:0] ST_CHECK = 4'd3;
  localparam logic [3:0] ST_MENU  = 4'd4;
  localparam logic [3:0] ST_BAL   = 4'd5;
  localparam logic [3:0] ST_DEP   = 4'd6;
  localparam logic [3:0] ST_WDR   = 4'd7;
  localparam logic [3:0] ST_UPD   = 4'd8;
  localparam logic [3:0] ST_EJECT = 4'd9;

  // Menu operation codes
  localparam logic [1:0] OP_BAL   = 2'b00;
  localparam logic [1:0] OP_DEP   = 2'b01;
  localparam logic [1:0] OP_WDR   = 2'b10;
  localparam logic [1:0] OP_EJECT = 2'b11;

  // Error codes reported on err with err_valid
  localparam logic [2:0] ERR_TIMEOUT      = 3'd0;
  localparam logic [2:0] ERR_BAD_CARD     = 3'd1;
  localparam logic [2:0] ERR_LOCKED       = 3'd2;
  localparam logic [2:0] ERR_BAD_PIN      = 3'd3;
  localparam logic [2:0] ERR_NOW_LOCKED   = 3'd4;
  localparam logic [2:0] ERR_ZERO_AMT     = 3'd5;
  localparam logic [2:0] ERR_OVERFLOW     = 3'd6;
  localparam logic [2:0] ERR_INSUFFICIENT = 3'd7;

  // Account i starts with balance i * INIT_BAL_STEP
  localparam int unsigned INIT_BAL_STEP = 1111;

  // States in which the controller is waiting on the customer and the
  // inactivity timer is running
  function automatic logic is_timed(input logic [3:0] s);
    return (s == ST_LANG) || (s == ST_PIN) || (s == ST_MENU) ||
           (s == ST_DEP)  || (s == ST_WDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/atm_account_db.sv
`default_nettype none
// ============================================================================
//  Module   : atm_account_db
//  Purpose  : Register-based account database. Combinational read of PIN,
//             balance, lock flag and try counter by card ID; one synchronous
//             write port updating balance, lock and tries together.
//  Revision : 1.0  initial release
// ============================================================================
module atm_account_db
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 8,
  parameter int PIN_DIGITS   = 4,
  parameter int BAL_W        = 32,
  parameter int ID_W         = 3,
  parameter int TRY_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_W-1:0]         rd_id,
  output logic [4*PIN_DIGITS-1:0] rd_pin,
  output logic [BAL_W-1:0]        rd_balance,
  output logic                    rd_lock,
  output logic [TRY_W-1:0]        rd_tries,
  input  logic                    wr_en,
  input  logic [ID_W-1:0]         wr_id,
  input  logic [BAL_W-1:0]        wr_balance,
  input  logic                    wr_lock,
  input  logic [TRY_W-1:0]        wr_tries
);

  // One slot per encodable ID so every read index is in range; slots at or
  // above NUM_ACCOUNTS stay zero because the controller never accepts them.
  localparam int DEPTH = 1 << ID_W;

  logic [BAL_W-1:0] balance_mem [DEPTH];
  logic [TRY_W-1:0] tries_mem   [DEPTH];
  logic [DEPTH-1:0] lock_mem;
  logic [3:0]       pin_digit;

  // PINs are fixed at their reset pattern (every digit = ID mod 10), so the
  // stored PIN reduces to a function of the ID.
  assign pin_digit  = 4'(32'(rd_id) % 32'd10);
  assign rd_pin     = {PIN_DIGITS{pin_digit}};
  assign rd_balance = balance_mem[rd_id];
  assign rd_lock    = lock_mem[rd_id];
  assign rd_tries   = tries_mem[rd_id];

  // Reset initialisation and the single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        balance_mem[i] <= (i < NUM_ACCOUNTS) ? BAL_W'(i * INIT_BAL_STEP) : '0;
        tries_mem[i]   <= '0;
        lock_mem[i]    <= 1'b0;
      end
    end else if (wr_en) begin
      balance_mem[wr_id] <= wr_balance;
      tries_mem[wr_id]   <= wr_tries;
      lock_mem[wr_id]    <= wr_lock;
    end
  end

endmodule
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : atm_session_ctrl
//  Purpose  : ATM card-session controller: card validation, language select,
//             PIN check with per-card lockout, balance/deposit/withdraw/eject
//             menu, inactivity timeout and card-removal abort. All outputs
//             are registered.
//  Revision : 1.0  initial release
// ============================================================================
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = 8,
  parameter int PIN_DIGITS     = 4,
  parameter int BAL_W          = 32,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ID_W           = $clog2(NUM_ACCOUNTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    card_in,
  input  logic [ID_W-1:0]         card_id,
  input  logic                    lang_valid,
  input  logic                    lang,
  input  logic                    pin_valid,
  input  logic [4*PIN_DIGITS-1:0] pin,
  input  logic                    op_valid,
  input  logic [1:0]              op,
  input  logic                    amt_valid,
  input  logic [BAL_W-1:0]        amt,
  output logic [3:0]              state,
  output logic                    lang_q,
  output logic [BAL_W-1:0]        balance_out,
  output logic                    balance_valid,
  output logic                    done,
  output logic [2:0]              err,
  output logic                    err_valid,
  output logic                    eject,
  output logic                    locked
);

  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DEPTH = 1 << ID_W;
  localparam int PIN_W = 4 * PIN_DIGITS;

  // Latched session data
  logic [ID_W-1:0]  card_q;
  logic [PIN_W-1:0] pin_q;
  logic [BAL_W-1:0] amt_q;
  logic             is_dep_q;
  logic             session_ok;
  logic [TO_W-1:0]  idle_cnt;

  // Database interface
  logic [ID_W-1:0]  rd_id;
  logic [PIN_W-1:0] rd_pin;
  logic [BAL_W-1:0] rd_balance;
  logic             rd_lock;
  logic [TRY_W-1:0] rd_tries;
  logic             wr_en;
  logic [BAL_W-1:0] wr_balance;
  logic             wr_lock;
  logic [TRY_W-1:0] wr_tries;

  // Next-state decisions
  logic [3:0]       nxt_state;
  logic [2:0]       nxt_err;
  logic             err_fire;
  logic             eject_fire;
  logic             bal_fire;
  logic [BAL_W-1:0] nxt_bal_out;
  logic             nxt_locked;
  logic             latch_card;
  logic             latch_lang;
  logic             latch_pin;
  logic             latch_amt;
  logic             ok_set;

  // Arithmetic helpers
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W-1:0] upd_balance;
  logic [TRY_W-1:0] tries_inc;
  logic             timeout_hit;
  logic [DEPTH-1:0] id_ok;

  // Table of card IDs that correspond to a real account (ID 0 reserved)
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_id_ok
      assign id_ok[g] = (g != 0) && (g < NUM_ACCOUNTS);
    end
  endgenerate

  // In IDLE the presented card is checked before it is latched
  assign rd_id       = (state == ST_IDLE) ? card_id : card_q;
  assign dep_sum     = {1'b0, rd_balance} + {1'b0, amt};
  assign upd_balance = is_dep_q ? (rd_balance + amt_q) : (rd_balance - amt_q);
  assign tries_inc   = rd_tries + TRY_W'(1);
  assign timeout_hit = is_timed(state) && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  atm_account_db #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .PIN_DIGITS   (PIN_DIGITS),
    .BAL_W        (BAL_W),
    .ID_W         (ID_W),
    .TRY_W        (TRY_W)
  ) u_db (
    .clk        (clk),
    .rst        (rst),
    .rd_id      (rd_id),
    .rd_pin     (rd_pin),
    .rd_balance (rd_balance),
    .rd_lock    (rd_lock),
    .rd_tries   (rd_tries),
    .wr_en      (wr_en),
    .wr_id      (card_q),
    .wr_balance (wr_balance),
    .wr_lock    (wr_lock),
    .wr_tries   (wr_tries)
  );

  // Session FSM: next state, output pulses and database writes
  always_comb begin
    nxt_state   = state;
    nxt_err     = err;
    err_fire    = 1'b0;
    eject_fire  = 1'b0;
    bal_fire    = 1'b0;
    nxt_bal_out = balance_out;
    nxt_locked  = locked;
    wr_en       = 1'b0;
    wr_balance  = rd_balance;
    wr_lock     = rd_lock;
    wr_tries    = rd_tries;
    latch_card  = 1'b0;
    latch_lang  = 1'b0;
    latch_pin   = 1'b0;
    latch_amt   = 1'b0;
    ok_set      = 1'b0;

    if (state == ST_IDLE) begin
      if (card_in) begin
        latch_card = 1'b1;
        if (!id_ok[card_id]) begin
          err_fire   = 1'b1;
          nxt_err    = ERR_BAD_CARD;
          eject_fire = 1'b1;
          nxt_locked = 1'b0;
        end else if (rd_lock) begin
          err_fire   = 1'b1;
          nxt_err    = ERR_LOCKED;
          eject_fire = 1'b1;
          nxt_locked = 1'b1;
        end else begin
          nxt_state  = ST_LANG;
          nxt_locked = 1'b0;
        end
      end
    end else if (state == ST_UPD) begin
      // The commit always completes, even if the card is pulled this cycle
      wr_en       = 1'b1;
      wr_balance  = upd_balance;
      bal_fire    = 1'b1;
      nxt_bal_out = upd_balance;
      nxt_state   = card_in ? ST_MENU : ST_IDLE;
    end else if (!card_in) begin
      // Card pulled: abandon the session silently
      nxt_state = ST_IDLE;
    end else begin
      case (state)
        ST_LANG: begin
          if (lang_valid) begin
            latch_lang = 1'b1;
            nxt_state  = ST_PIN;
          end
        end
        ST_PIN: begin
          if (pin_valid) begin
            latch_pin = 1'b1;
            nxt_state = ST_CHECK;
          end
        end
        ST_CHECK: begin
          wr_en = 1'b1;
          if (pin_q == rd_pin) begin
            wr_tries  = '0;
            ok_set    = 1'b1;
            nxt_state = ST_MENU;
          end else begin
            wr_tries = tries_inc;
            err_fire = 1'b1;
            if (tries_inc == TRY_W'(MAX_PIN_TRIES)) begin
              wr_lock    = 1'b1;
              nxt_locked = 1'b1;
              nxt_err    = ERR_NOW_LOCKED;
              nxt_state  = ST_EJECT;
            end else begin
              nxt_err   = ERR_BAD_PIN;
              nxt_state = ST_PIN;
            end
          end
        end
        ST_MENU: begin
          if (op_valid) begin
            case (op)
              OP_BAL:  nxt_state = ST_BAL;
              OP_DEP:  nxt_state = ST_DEP;
              OP_WDR:  nxt_state = ST_WDR;
              default: nxt_state = ST_EJECT;
            endcase
          end
        end
        ST_BAL: begin
          bal_fire    = 1'b1;
          nxt_bal_out = rd_balance;
          nxt_state   = ST_MENU;
        end
        ST_DEP: begin
          if (amt_valid) begin
            latch_amt = 1'b1;
            if (amt == '0) begin
              err_fire  = 1'b1;
              nxt_err   = ERR_ZERO_AMT;
              nxt_state = ST_MENU;
            end else if (dep_sum[BAL_W]) begin
              err_fire  = 1'b1;
              nxt_err   = ERR_OVERFLOW;
              nxt_state = ST_MENU;
            end else begin
              nxt_state = ST_UPD;
            end
          end
        end
        ST_WDR: begin
          if (amt_valid) begin
            latch_amt = 1'b1;
            if (amt == '0) begin
              err_fire  = 1'b1;
              nxt_err   = ERR_ZERO_AMT;
              nxt_state = ST_MENU;
            end else if (amt > rd_balance) begin
              err_fire  = 1'b1;
              nxt_err   = ERR_INSUFFICIENT;
              nxt_state = ST_MENU;
            end else begin
              nxt_state = ST_UPD;
            end
          end
        end
        ST_EJECT: begin
          eject_fire = 1'b1;
          nxt_state  = ST_IDLE;
          if (session_ok) begin
            wr_en    = 1'b1;
            wr_tries = '0;
          end
        end
        default: nxt_state = ST_IDLE;
      endcase

      // Every accepted strobe leaves the state, so timeout only fires when
      // the customer did nothing this cycle.
      if (timeout_hit && (nxt_state == state)) begin
        err_fire  = 1'b1;
        nxt_err   = ERR_TIMEOUT;
        nxt_state = ST_EJECT;
      end
    end
  end

  // State, registered outputs and latched session data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      lang_q        <= 1'b0;
      balance_out   <= '0;
      balance_valid <= 1'b0;
      done          <= 1'b0;
      err           <= 3'd0;
      err_valid     <= 1'b0;
      eject         <= 1'b0;
      locked        <= 1'b0;
      card_q        <= '0;
      pin_q         <= '0;
      amt_q         <= '0;
      is_dep_q      <= 1'b0;
      session_ok    <= 1'b0;
    end else begin
      state         <= nxt_state;
      balance_valid <= bal_fire;
      done          <= bal_fire;
      balance_out   <= nxt_bal_out;
      err_valid     <= err_fire;
      err           <= nxt_err;
      eject         <= eject_fire;
      locked        <= nxt_locked;
      if (latch_card) card_q <= card_id;
      if (latch_lang) lang_q <= lang;
      if (latch_pin)  pin_q  <= pin;
      if (latch_amt) begin
        amt_q    <= amt;
        is_dep_q <= (state == ST_DEP);
      end
      if (latch_card)  session_ok <= 1'b0;
      else if (ok_set) session_ok <= 1'b1;
    end
  end

  // Inactivity counter: restarts on any state change, idle outside waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((nxt_state != state) || !is_timed(state)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atm_session_ctrl
//  Purpose  : Self-checking bench for atm_session_ctrl: directed scenarios
//             followed by random sessions against an account-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_atm_session_ctrl;

  localparam int NA = 8;
  localparam int PD = 4;
  localparam int BW = 16;
  localparam int MT = 3;
  localparam int TO = 64;
  localparam int IW = 3;
  localparam longint BAL_MAX = (64'd1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          card_in;
  logic [IW-1:0] card_id;
  logic          lang_valid;
  logic          lang;
  logic          pin_valid;
  logic [4*PD-1:0] pin;
  logic          op_valid;
  logic [1:0]    op;
  logic          amt_valid;
  logic [BW-1:0] amt;
  logic [3:0]    state;
  logic          lang_q;
  logic [BW-1:0] balance_out;
  logic          balance_valid;
  logic          done;
  logic [2:0]    err;
  logic          err_valid;
  logic          eject;
  logic          locked;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .NUM_ACCOUNTS(NA), .PIN_DIGITS(PD), .BAL_W(BW),
    .MAX_PIN_TRIES(MT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_id(card_id),
    .lang_valid(lang_valid), .lang(lang), .pin_valid(pin_valid), .pin(pin),
    .op_valid(op_valid), .op(op), .amt_valid(amt_valid), .amt(amt),
    .state(state), .lang_q(lang_q), .balance_out(balance_out),
    .balance_valid(balance_valid), .done(done), .err(err),
    .err_valid(err_valid), .eject(eject), .locked(locked)
  );

  int checks = 0;
  int errors = 0;

  // Account-level reference model
  longint mbal   [NA];
  bit     mlock  [NA];
  int     mtries [NA];

  // Per-action observations
  int cyc, n_err, n_eject, n_bv, n_done, bv_at, err_at;
  int last_err;
  longint last_bal;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NA; c++) begin
      mbal[c]   = (c * 1111) & BAL_MAX;
      mlock[c]  = 1'b0;
      mtries[c] = 0;
    end
  endtask

  task automatic clear_obs();
    cyc = 0; n_err = 0; n_eject = 0; n_bv = 0; n_done = 0;
    bv_at = -1; err_at = -1; last_err = -1; last_bal = -1;
  endtask

  // One clock; observe the registered outputs just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (err_valid) begin n_err++; last_err = int'(err); err_at = cyc; end
    if (eject) n_eject++;
    if (balance_valid) begin n_bv++; last_bal = longint'(balance_out); bv_at = cyc; end
    if (done) n_done++;
  endtask

  task automatic run_until(input string tag, input logic [3:0] target, input int maxc);
    int k;
    k = 0;
    while (state !== target && k < maxc) begin
      tick();
      k++;
    end
    check(tag, longint'(state), longint'(target));
  endtask

  function automatic logic [4*PD-1:0] pin_for(input int c, input bit good);
    logic [3:0] d;
    logic [4*PD-1:0] p;
    d = 4'(c % 10);
    p = {PD{d}};
    if (!good) p[3:0] = 4'((c + 1) % 10);
    return p;
  endfunction

  task automatic insert(input int c, output bit accepted);
    int code;
    clear_obs();
    card_in = 1'b1;
    card_id = IW'(c);
    tick();
    accepted = 1'b0;
    if (c == 0 || c >= NA || mlock[c]) begin
      code = (c == 0 || c >= NA) ? 1 : 2;
      check("reject_err", last_err, code);
      check("reject_eject", n_eject, 1);
      check("reject_state", longint'(state), 0);
      if (code == 2) check("reject_locked", longint'(locked), 1);
      card_in = 1'b0;
    end else begin
      check("insert_state", longint'(state), 1);
      check("insert_noerr", n_err, 0);
      accepted = 1'b1;
    end
  endtask

  task automatic lang_step(input bit l);
    lang_valid = 1'b1;
    lang = l;
    tick();
    lang_valid = 1'b0;
    check("lang_state", longint'(state), 2);
    check("lang_q", longint'(lang_q), longint'(l));
  endtask

  task automatic pin_step(input int c, input bit good, output bit in_menu);
    logic [3:0] target;
    clear_obs();
    pin_valid = 1'b1;
    pin = pin_for(c, good);
    tick();
    pin_valid = 1'b0;
    in_menu = 1'b0;
    if (good) begin
      mtries[c] = 0;
      run_until("pin_ok_state", 4'd4, 6);
      check("pin_ok_noerr", n_err, 0);
      in_menu = 1'b1;
    end else begin
      mtries[c]++;
      if (mtries[c] >= MT) begin
        mlock[c] = 1'b1;
        run_until("pin_lock_state", 4'd0, 6);
        check("pin_lock_err", last_err, 4);
        check("pin_lock_nerr", n_err, 1);
        check("pin_lock_eject", n_eject, 1);
        check("pin_lock_flag", longint'(locked), 1);
        card_in = 1'b0;
      end else begin
        run_until("pin_bad_state", 4'd2, 6);
        check("pin_bad_err", last_err, 3);
        check("pin_bad_eject", n_eject, 0);
      end
    end
  endtask

  task automatic open_session(input int c);
    bit acc, m;
    insert(c, acc);
    if (acc) begin
      lang_step(1'($urandom_range(0, 1)));
      pin_step(c, 1'b1, m);
    end
  endtask

  task automatic op_step(input int c, input int o, input longint a);
    int code;
    clear_obs();
    op_valid = 1'b1;
    op = 2'(o);
    tick();
    op_valid = 1'b0;
    if (o == 0) begin
      run_until("bal_state", 4'd4, 6);
      check("bal_value", last_bal, mbal[c]);
      check("bal_latency", bv_at, 2);
      check("bal_done", n_done, 1);
    end else if (o == 3) begin
      run_until("eject_state", 4'd0, 6);
      check("eject_pulse", n_eject, 1);
      check("eject_noerr", n_err, 0);
      card_in = 1'b0;
      mtries[c] = 0;
    end else begin
      check("amt_state", longint'(state), (o == 1) ? 6 : 7);
      amt_valid = 1'b1;
      amt = BW'(a);
      tick();
      amt_valid = 1'b0;
      run_until("amt_menu", 4'd4, 6);
      code = -1;
      if (a == 0) code = 5;
      else if (o == 1 && mbal[c] + a > BAL_MAX) code = 6;
      else if (o == 2 && a > mbal[c]) code = 7;
      if (code >= 0) begin
        check("amt_err", last_err, code);
        check("amt_err_nobal", n_bv, 0);
      end else begin
        mbal[c] = (o == 1) ? mbal[c] + a : mbal[c] - a;
        check("amt_new_bal", last_bal, mbal[c]);
        check("amt_done", n_done, 1);
        check("amt_noerr", n_err, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, m;
    int c, r, nops, o;
    longint a;

    rst = 1'b1; card_in = 1'b0; card_id = '0; lang_valid = 1'b0; lang = 1'b0;
    pin_valid = 1'b0; pin = '0; op_valid = 1'b0; op = '0; amt_valid = 1'b0; amt = '0;
    model_reset();
    #2;
    check("rst_state", longint'(state), 0);
    check("rst_eject", longint'(eject), 0);
    check("rst_errv", longint'(err_valid), 0);
    check("rst_balv", longint'(balance_valid), 0);
    check("rst_locked", longint'(locked), 0);
    check("rst_balout", longint'(balance_out), 0);
    @(posedge clk); #1; rst = 1'b0;
    tick();

    // Card 3 balance enquiry
    open_session(3);
    op_step(3, 0, 0);
    op_step(3, 3, 0);

    // Card 2: deposit, exact withdraw, insufficient funds
    open_session(2);
    op_step(2, 1, 100);
    op_step(2, 2, 2322);
    op_step(2, 2, 1);
    op_step(2, 0, 0);
    op_step(2, 3, 0);

    // Card 5: three wrong PINs lock it, reinsertion is refused
    insert(5, acc);
    lang_step(1'b0);
    for (int i = 0; i < MT; i++) pin_step(5, 1'b0, m);
    insert(5, acc);

    // Card 7: overflow and zero amount
    open_session(7);
    op_step(7, 1, 60000);
    op_step(7, 0, 0);
    op_step(7, 1, 0);
    op_step(7, 3, 0);

    // Card 1: idle in MENU until timeout
    open_session(1);
    clear_obs();
    run_until("timeout_state", 4'd0, TO + 10);
    check("timeout_err", last_err, 0);
    check("timeout_nerr", n_err, 1);
    check("timeout_eject", n_eject, 1);
    check("timeout_window", longint'(err_at >= TO - 1 && err_at <= TO + 1), 1);
    card_in = 1'b0;
    tick();

    // Invalid IDs (8 does not fit the 3-bit port and arrives as 0)
    insert(0, acc);
    insert(8, acc);

    // Card pulled during PIN entry
    insert(4, acc);
    lang_step(1'b1);
    clear_obs();
    card_in = 1'b0;
    tick();
    check("pull_pin_state", longint'(state), 0);
    check("pull_pin_eject", n_eject, 0);

    // Card pulled in UPD: the deposit still commits
    open_session(6);
    clear_obs();
    op_valid = 1'b1; op = 2'b01; tick(); op_valid = 1'b0;
    amt_valid = 1'b1; amt = 16'd500; tick(); amt_valid = 1'b0;
    check("upd_state", longint'(state), 8);
    card_in = 1'b0;
    tick();
    check("pull_upd_state", longint'(state), 0);
    check("pull_upd_eject", n_eject, 0);
    mbal[6] = mbal[6] + 500;
    open_session(6);
    op_step(6, 0, 0);
    op_step(6, 3, 0);

    // Reset in MENU restores the database
    open_session(2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_state", longint'(state), 0);
    card_in = 1'b0;
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    open_session(2);
    op_step(2, 0, 0);
    op_step(2, 3, 0);
    open_session(5);
    op_step(5, 0, 0);
    op_step(5, 3, 0);

    // Random sessions
    for (int s = 0; s < 30; s++) begin
      c = $urandom_range(0, NA - 1);
      insert(c, acc);
      if (!acc) begin tick(); continue; end
      lang_step(1'($urandom_range(0, 1)));
      m = 1'b0;
      for (int t = 0; t < MT && !m && !mlock[c]; t++)
        pin_step(c, ($urandom_range(0, 3) != 0), m);
      if (!m) begin
        if (!mlock[c]) begin
          clear_obs();
          card_in = 1'b0;
          tick();
          check("rand_pull_state", longint'(state), 0);
        end
        tick();
        continue;
      end
      nops = $urandom_range(1, 4);
      for (int k = 0; k < nops; k++) begin
        o = $urandom_range(0, 2);
        r = $urandom_range(0, 4);
        case (r)
          0: a = 0;
          1: a = $urandom_range(1, 500);
          2: a = mbal[c];
          3: a = $urandom_range(60000, 65535);
          default: a = (mbal[c] + 1) & BAL_MAX;
        endcase
        op_step(c, o, a);
      end
      op_step(c, 3, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
